// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive controller: FSM encoding, FIFO entry
// width and the character-timeout terminal count.
package uart_pkg;

  typedef enum logic {StDisabled = 1'b0, StActive = 1'b1} rx_state_e;

  // Each FIFO entry carries the data byte plus its framing-error tag.
  localparam int unsigned FERR_W = 1;

  function automatic int unsigned entry_width(input int unsigned data_bits);
    return data_bits + FERR_W;
  endfunction

  // Start + data + stop bits, times oversample, times idle characters.
  function automatic int unsigned timeout_term(input int unsigned chars,
                                               input int unsigned data_bits,
                                               input int unsigned oversample);
    return chars * (data_bits + 2) * oversample;
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count; a push into a
// full FIFO is accepted only when a pop happens in the same cycle.
module uart_sync_fifo #(
  parameter int unsigned WIDTH = 9,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty,
  output logic                   full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign empty = (r_count == '0);
  assign full  = (r_count == CW'(DEPTH));
  assign count = r_count;
  assign rdata = r_mem[r_rptr];

  assign w_do_pop  = pop && !empty && !flush;
  assign w_do_push = push && !flush && (!full || w_do_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + AW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push && !rst) r_mem[r_wptr] <= wdata;
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: enable FSM, receive FIFO, overrun/interrupt flags.
// Define UART_RX_TIMEOUT_EN to build the character-timeout counter.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned DATA_BITS     = 8,
  parameter int unsigned FIFO_DEPTH    = 16,
  parameter int unsigned OVERSAMPLE    = 16,
  parameter int unsigned TIMEOUT_CHARS = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic                        baud_tick,
  input  logic [DATA_BITS-1:0]        rx_data,
  input  logic                        rx_valid,
  input  logic                        rx_frame_error,
  output logic                        rx_en,
  input  logic                        rd_en,
  output logic [DATA_BITS-1:0]        rd_data,
  output logic                        rd_ferr,
  input  logic                        flush,
  input  logic [$clog2(FIFO_DEPTH):0] thresh,
  input  logic                        clr_ovr,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        empty,
  output logic                        full,
  output logic                        overrun,
  output logic                        timeout,
  output logic                        irq
);

  localparam int unsigned ENTRY_W = entry_width(DATA_BITS);
  localparam int unsigned TO_TERM = timeout_term(TIMEOUT_CHARS, DATA_BITS, OVERSAMPLE);

  rx_state_e          r_state;
  rx_state_e          w_state_next;
  logic               w_active;
  logic               w_push;
  logic               w_ovr_set;
  logic [ENTRY_W-1:0] w_rdata;
  logic               r_overrun;
  logic               r_irq;

  always_ff @(posedge clk) begin
    if (rst) r_state <= StDisabled;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StDisabled: if (enable)  w_state_next = StActive;
      StActive:   if (!enable) w_state_next = StDisabled;
    endcase
  end

  always_comb begin
    w_active = (r_state == StActive);
    rx_en    = w_active;
  end

  assign w_push = rx_valid && w_active;

  uart_sync_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (flush),
    .push  (w_push),
    .pop   (rd_en),
    .wdata ({rx_frame_error, rx_data}),
    .rdata (w_rdata),
    .count (count),
    .empty (empty),
    .full  (full)
  );

  assign rd_data = w_rdata[DATA_BITS-1:0];
  assign rd_ferr = w_rdata[DATA_BITS];

  // A pop in the same cycle frees a slot, so only an unmatched push overflows.
  assign w_ovr_set = w_push && full && !rd_en && !flush;

  always_ff @(posedge clk) begin
    if (rst || flush)   r_overrun <= 1'b0;
    else if (w_ovr_set) r_overrun <= 1'b1;
    else if (clr_ovr)   r_overrun <= 1'b0;
  end

  assign overrun = r_overrun;

`ifdef UART_RX_TIMEOUT_EN
  localparam int unsigned TO_W = $clog2(TO_TERM) + 1;

  logic [TO_W-1:0] r_to_cnt;
  logic            r_timeout;
  logic            w_push_eff;
  logic            w_pop_eff;

  assign w_pop_eff  = rd_en && !empty && !flush;
  assign w_push_eff = w_push && !flush && (!full || w_pop_eff);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      r_to_cnt  <= '0;
      r_timeout <= 1'b0;
    end else begin
      if (w_push_eff || w_pop_eff) begin
        r_to_cnt <= '0;
      end else if (w_active && !empty && baud_tick && (r_to_cnt != TO_W'(TO_TERM))) begin
        r_to_cnt <= r_to_cnt + TO_W'(1);
      end
      if (w_pop_eff)                         r_timeout <= 1'b0;
      else if (r_to_cnt == TO_W'(TO_TERM))   r_timeout <= 1'b1;
    end
  end

  assign timeout = r_timeout;
`else
  logic w_unused_to;
  assign w_unused_to = baud_tick ^ (TO_TERM == 0);
  assign timeout     = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) r_irq <= 1'b0;
    else     r_irq <= ((thresh != '0) && (count >= thresh)) | r_overrun | timeout;
  end

  assign irq = r_irq;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl (default parameters).
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst, enable, baud_tick, rx_valid, rx_frame_error, rd_en, flush, clr_ovr;
  logic [7:0] rx_data;
  logic [4:0] thresh;
  logic       rx_en, rd_ferr, empty, full, overrun, timeout, irq;
  logic [7:0] rd_data;
  logic [4:0] count;
  int         checks = 0;
  int         failures = 0;

  uart_rx_ctrl dut (
    .clk            (clk),
    .rst            (rst),
    .enable         (enable),
    .baud_tick      (baud_tick),
    .rx_data        (rx_data),
    .rx_valid       (rx_valid),
    .rx_frame_error (rx_frame_error),
    .rx_en          (rx_en),
    .rd_en          (rd_en),
    .rd_data        (rd_data),
    .rd_ferr        (rd_ferr),
    .flush          (flush),
    .thresh         (thresh),
    .clr_ovr        (clr_ovr),
    .count          (count),
    .empty          (empty),
    .full           (full),
    .overrun        (overrun),
    .timeout        (timeout),
    .irq            (irq)
  );

  always #5 clk = ~clk;

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic push_byte(input logic [7:0] d, input logic fe);
    @(negedge clk);
    rx_valid = 1'b1; rx_data = d; rx_frame_error = fe;
    @(negedge clk);
    rx_valid = 1'b0; rx_frame_error = 1'b0;
  endtask

  task automatic pop_byte();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic do_flush();
    @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; baud_tick = 1'b0; rx_valid = 1'b0; rx_frame_error = 1'b0;
    rx_data = 8'h00; rd_en = 1'b0; flush = 1'b0; clr_ovr = 1'b0; thresh = 5'd0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({count, empty, full, overrun, timeout, irq, rx_en} !== {5'd0, 1'b1, 5'b00000}) begin
      failures++;
      $display("FAIL reset_state got count=%0d e=%b f=%b o=%b t=%b i=%b rx_en=%b, want 0 1 0 0 0 0 0",
               count, empty, full, overrun, timeout, irq, rx_en);
    end
  endtask

  task automatic test_basic();
    enable = 1'b1;
    @(negedge clk);
    checks++;
    if (rx_en !== 1'b1) begin failures++; $display("FAIL rx_en_active got %b want 1", rx_en); end
    push_byte(8'hA5, 1'b0);
    push_byte(8'h3C, 1'b0);
    checks++;
    if (count !== 5'd2 || rd_data !== 8'hA5) begin
      failures++;
      $display("FAIL basic_push got count=%0d data=%h want 2 a5", count, rd_data);
    end
    pop_byte();
    checks++;
    if (rd_data !== 8'h3C || count !== 5'd1) begin
      failures++;
      $display("FAIL basic_pop got data=%h count=%0d want 3c 1", rd_data, count);
    end
    pop_byte();
    pop_byte();  // pop while empty must be ignored
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL pop_empty got count=%0d e=%b o=%b want 0 1 0", count, empty, overrun);
    end
  endtask

  task automatic test_overrun();
    for (int i = 0; i < 16; i++) push_byte(8'(i), 1'b0);
    checks++;
    if (full !== 1'b1 || count !== 5'd16) begin
      failures++;
      $display("FAIL fill_full got full=%b count=%0d want 1 16", full, count);
    end
    push_byte(8'hEE, 1'b0);
    checks++;
    if (overrun !== 1'b1 || count !== 5'd16 || rd_data !== 8'h00) begin
      failures++;
      $display("FAIL overrun_set got o=%b count=%0d head=%h want 1 16 00", overrun, count, rd_data);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL overrun_irq got %b want 1", irq); end
    @(negedge clk);
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b0) begin failures++; $display("FAIL clr_ovr got %b want 0", overrun); end
    // Set coincident with clear: set wins.
    rx_valid = 1'b1; rx_data = 8'hEF; clr_ovr = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; clr_ovr = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set_wins got %b want 1", overrun); end
    clr_ovr = 1'b1;
    @(negedge clk);
    clr_ovr = 1'b0;
  endtask

  task automatic test_full_push_pop();
    @(negedge clk);
    rx_valid = 1'b1; rx_data = 8'h77; rd_en = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rd_en = 1'b0;
    checks++;
    if (count !== 5'd16 || overrun !== 1'b0 || rd_data !== 8'h01) begin
      failures++;
      $display("FAIL full_push_pop got count=%0d o=%b head=%h want 16 0 01", count, overrun, rd_data);
    end
    for (int i = 0; i < 15; i++) pop_byte();
    checks++;
    if (rd_data !== 8'h77 || count !== 5'd1) begin
      failures++;
      $display("FAIL newest_at_tail got data=%h count=%0d want 77 1", rd_data, count);
    end
  endtask

  task automatic test_thresh();
    do_flush();
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) push_byte(8'h10 + 8'(i), 1'b0);
    @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL thresh_below got irq=%b want 0", irq); end
    push_byte(8'h13, 1'b0);
    checks++;
    if (count !== 5'd4 || irq !== 1'b0) begin
      failures++;
      $display("FAIL thresh_lag got count=%0d irq=%b want 4 0", count, irq);
    end
    @(negedge clk);
    checks++;
    if (irq !== 1'b1) begin failures++; $display("FAIL thresh_hit got irq=%b want 1", irq); end
    thresh = 5'd0;
    repeat (2) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin failures++; $display("FAIL thresh_zero got irq=%b want 0", irq); end
  endtask

  task automatic test_timeout();
    logic exp_to;
`ifdef UART_RX_TIMEOUT_EN
    exp_to = 1'b1;
`else
    exp_to = 1'b0;
`endif
    do_flush();
    push_byte(8'h42, 1'b0);
    baud_tick = 1'b1;
    repeat (639) @(negedge clk);
    checks++;
    if (timeout !== 1'b0) begin failures++; $display("FAIL timeout_early got %b want 0", timeout); end
    @(negedge clk);
    baud_tick = 1'b0;
    @(negedge clk);
    checks++;
    if (timeout !== exp_to) begin
      failures++;
      $display("FAIL timeout_set got %b want %b", timeout, exp_to);
    end
    @(negedge clk);
    checks++;
    if (irq !== exp_to) begin failures++; $display("FAIL timeout_irq got %b want %b", irq, exp_to); end
    pop_byte();
    checks++;
    if (timeout !== 1'b0 || empty !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pop got t=%b e=%b want 0 1", timeout, empty);
    end
  endtask

  task automatic test_ferr_flush();
    push_byte(8'h5A, 1'b1);
    checks++;
    if (rd_ferr !== 1'b1 || rd_data !== 8'h5A) begin
      failures++;
      $display("FAIL ferr_head got ferr=%b data=%h want 1 5a", rd_ferr, rd_data);
    end
    push_byte(8'h6B, 1'b0);
    @(negedge clk);
    flush = 1'b1; rx_valid = 1'b1; rx_data = 8'h99;
    @(negedge clk);
    flush = 1'b0; rx_valid = 1'b0;
    checks++;
    if (empty !== 1'b1 || count !== 5'd0) begin
      failures++;
      $display("FAIL flush_push got e=%b count=%0d want 1 0", empty, count);
    end
  endtask

  task automatic test_disabled();
    push_byte(8'h11, 1'b0);
    @(negedge clk);
    enable = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_en !== 1'b0) begin failures++; $display("FAIL rx_en_disabled got %b want 0", rx_en); end
    push_byte(8'h22, 1'b0);
    checks++;
    if (count !== 5'd1 || rd_data !== 8'h11) begin
      failures++;
      $display("FAIL disabled_ignore got count=%0d data=%h want 1 11", count, rd_data);
    end
    pop_byte();
    checks++;
    if (empty !== 1'b1) begin failures++; $display("FAIL disabled_pop got e=%b want 1", empty); end
  endtask

  task automatic test_reset_priority();
    enable = 1'b1;
    push_byte(8'h33, 1'b0);
    push_byte(8'h44, 1'b0);
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b1; rx_data = 8'h55; flush = 1'b0; clr_ovr = 1'b1;
    @(negedge clk);
    rst = 1'b0; rx_valid = 1'b0; clr_ovr = 1'b0; enable = 1'b0;
    checks++;
    if (count !== 5'd0 || empty !== 1'b1 || rx_en !== 1'b0 || irq !== 1'b0) begin
      failures++;
      $display("FAIL reset_priority got count=%0d e=%b rx_en=%b irq=%b want 0 1 0 0",
               count, empty, rx_en, irq);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_full_push_pop();
    test_thresh();
    test_timeout();
    test_ferr_flush();
    test_disabled();
    test_reset_priority();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
